// File: rtl/cla_pkg.sv
// Shared types for the 5-bit CLA subtractor datapath.
package cla_pkg;

    localparam int unsigned CLA_W = 5;

    typedef logic [CLA_W-1:0] operand_t;

    typedef struct packed {
        operand_t diff;
        logic     bout;
        logic     ovf;
    } sub_result_t;

endpackage

// File: rtl/cla_core_5bit.sv
// Combinational 5-bit carry-lookahead adder with hand-expanded carry terms.
module cla_core_5bit
    import cla_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    input  logic     cin,
    output operand_t sum,
    output logic     cout
);

    operand_t g;
    operand_t p;
    logic     c1;
    logic     c2;
    logic     c3;
    logic     c4;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of generate/propagate products, no rippling.
    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign cout = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
                | (p[4] & p[3] & p[2] & g[1])
                | (p[4] & p[3] & p[2] & p[1] & g[0])
                | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c4, c3, c2, c1, cin};

endmodule

// File: rtl/cla_subtractor_5bit_pipe.sv
// Two-stage valid/ready pipelined subtractor: A - B - Bin computed as A + ~B + ~Bin.
module cla_subtractor_5bit_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_ovf
);

    logic        s1_valid;
    operand_t    s1_a;
    operand_t    s1_nb;
    logic        s1_cin;
    logic        s2_valid;
    sub_result_t s2_res;

    logic        s2_free;
    logic        s1_adv;
    logic        accept;
    operand_t    core_sum;
    logic        core_cout;
    sub_result_t core_res;

    assign s2_free  = ~s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_free;
    assign in_ready = ~s1_valid | s2_free;
    assign accept   = in_valid & in_ready;

    cla_core_5bit u_core (
        .a    (s1_a),
        .b    (s1_nb),
        .cin  (s1_cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Operand signs differ exactly when s1_a[4] equals the inverted B sign bit.
    always_comb begin
        core_res      = '0;
        core_res.diff = core_sum;
        core_res.bout = ~core_cout;
        core_res.ovf  = (s1_a[4] == s1_nb[4]) & (core_sum[4] != s1_a[4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_nb    <= '0;
            s1_cin   <= 1'b0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else begin
            if (accept) begin
                s1_a   <= in_a;
                s1_nb  <= ~in_b;
                s1_cin <= ~in_bin;
            end

            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                s2_res   <= core_res;
                s2_valid <= 1'b1;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_diff  = s2_res.diff;
    assign out_bout  = s2_res.bout;
    assign out_ovf   = s2_res.ovf;

endmodule

// File: tb/tb_cla_subtractor_5bit_pipe.sv
// Bench for the pipelined 5-bit subtractor: directed cases plus a full operand sweep.
module tb_cla_subtractor_5bit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_a;
    logic [4:0] in_b;
    logic       in_bin;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_diff;
    logic       out_bout;
    logic       out_ovf;

    typedef struct {
        int d;
        int bo;
        int ov;
    } exp_t;

    exp_t q[$];
    int   errors;
    int   checks;
    int   delivered;

    cla_subtractor_5bit_pipe #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Plain integer arithmetic: unsigned borrow and signed range overflow.
    function automatic exp_t model(int a, int b, int bin);
        exp_t e;
        int sa, sb, sd;
        e.d  = (a - b - bin) & 31;
        e.bo = (a < b + bin) ? 1 : 0;
        sa   = (a >= 16) ? a - 32 : a;
        sb   = (b >= 16) ? b - 32 : b;
        sd   = sa - sb - bin;
        e.ov = (sd > 15 || sd < -16) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, score the handshake just before the edge.
    task automatic step(input bit iv, input int a, input int b, input int bi,
                        input bit ordy, output bit accepted);
        exp_t e;
        in_valid  = iv;
        in_a      = 5'(a);
        in_b      = 5'(b);
        in_bin    = 1'(bi);
        out_ready = ordy;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = q[0];
                chk("sb_diff", int'(out_diff), e.d);
                chk("sb_bout", int'(out_bout), e.bo);
                chk("sb_ovf",  int'(out_ovf),  e.ov);
                if (out_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(model(a, b, bi));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        bit done;
        errors    = 0;
        checks    = 0;
        delivered = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_diff",  int'(out_diff),  0);
        chk("rst_out_bout",  int'(out_bout),  0);
        chk("rst_out_ovf",   int'(out_ovf),   0);
        chk("rst_in_ready",  int'(in_ready),  1);

        // Basic with latency
        step(1, 9, 4, 0, 1, acc);
        chk("lat_not_yet", int'(out_valid), 0);
        step(0, 0, 0, 0, 1, acc);
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_diff",  int'(out_diff),  5);
        chk("basic_bout",  int'(out_bout),  0);
        chk("basic_ovf",   int'(out_ovf),   0);
        step(0, 0, 0, 0, 1, acc);

        // Borrow cases back to back
        step(1, 4, 9, 0, 1, acc);
        step(1, 10, 3, 1, 1, acc);
        chk("borrow_diff", int'(out_diff), 27);
        chk("borrow_bout", int'(out_bout), 1);
        chk("borrow_ovf",  int'(out_ovf),  0);
        step(0, 0, 0, 0, 1, acc);
        chk("borrow2_diff", int'(out_diff), 6);
        chk("borrow2_bout", int'(out_bout), 0);
        step(0, 0, 0, 0, 1, acc);

        // Signed overflow
        step(1, 15, 16, 0, 1, acc);
        step(1, 16, 1, 0, 1, acc);
        chk("ovf1_diff", int'(out_diff), 31);
        chk("ovf1_bout", int'(out_bout), 1);
        chk("ovf1_ovf",  int'(out_ovf),  1);
        step(0, 0, 0, 0, 1, acc);
        chk("ovf2_diff", int'(out_diff), 15);
        chk("ovf2_bout", int'(out_bout), 0);
        chk("ovf2_ovf",  int'(out_ovf),  1);
        step(0, 0, 0, 0, 1, acc);

        // Extremes
        step(1, 0, 31, 1, 1, acc);
        step(1, 31, 0, 0, 1, acc);
        chk("ext1_diff", int'(out_diff), 0);
        chk("ext1_bout", int'(out_bout), 1);
        step(0, 0, 0, 0, 1, acc);
        chk("ext2_diff", int'(out_diff), 31);
        chk("ext2_bout", int'(out_bout), 0);
        step(0, 0, 0, 0, 1, acc);

        // Backpressure: two items fill the pipe, third is refused
        step(1, 1, 1, 0, 0, acc);
        chk("bp_acc1", int'(acc), 1);
        step(1, 2, 1, 0, 0, acc);
        chk("bp_acc2", int'(acc), 1);
        chk("bp_full_in_ready", int'(in_ready), 0);
        chk("bp_hold_diff", int'(out_diff), 0);
        step(1, 3, 1, 0, 0, acc);
        chk("bp_acc3_refused", int'(acc), 0);
        chk("bp_hold_diff2", int'(out_diff), 0);
        step(1, 3, 1, 0, 1, acc);
        chk("bp_acc3", int'(acc), 1);
        chk("bp_res1_valid", int'(out_valid), 1);
        chk("bp_res1", int'(out_diff), 1);
        step(0, 0, 0, 0, 1, acc);
        chk("bp_res2_valid", int'(out_valid), 1);
        chk("bp_res2", int'(out_diff), 2);
        step(0, 0, 0, 0, 1, acc);
        chk("bp_drained", q.size(), 0);

        // Reset with two items in flight
        step(1, 5, 1, 0, 0, acc);
        step(1, 6, 1, 0, 0, acc);
        chk("rmid_full", int'(in_ready), 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, acc);
        rst = 1'b0;
        q.delete();
        #1;
        chk("rmid_out_valid", int'(out_valid), 0);
        chk("rmid_out_diff",  int'(out_diff),  0);
        chk("rmid_out_bout",  int'(out_bout),  0);
        chk("rmid_out_ovf",   int'(out_ovf),   0);
        chk("rmid_in_ready",  int'(in_ready),  1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, acc);
            chk("rmid_no_stale", int'(out_valid), 0);
        end

        // Full sweep with random backpressure
        delivered = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    done = 1'b0;
                    for (int t = 0; t < 100 && !done; t++) begin
                        step(1, a, b, bi, 1'($urandom_range(0, 1)), acc);
                        done = acc;
                    end
                    if (!done) chk("sweep_accept_timeout", 0, 1);
                end
            end
        end
        for (int t = 0; t < 50 && q.size() != 0; t++) begin
            step(0, 0, 0, 0, 1, acc);
        end
        chk("sweep_drain", q.size(), 0);
        chk("sweep_count", delivered, 2048);
        step(0, 0, 0, 0, 1, acc);
        chk("sweep_idle", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
